inst_fetch_unit: RTL and testbench

Parametrised instruction fetch front end that replaces the single-request preIF/IF pair. It keeps up to `OUTSTANDING` requests in flight on the SRAM-like instruction port and queues returned instructions in an `IBUF_DEPTH`-entry instruction buffer. The buffer drains into ID through the standard valid/allowin handshake. It sits between the instruction-side SRAM bridge and the ID stage, and takes redirects from ID (branch) and WB (exception/ertn flush).

---
 rtl/inst_fetch_unit_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/inst_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: bus widths, exception bit indices and the
// IF<->ID bundle layouts shared by the fetch front end.
package inst_fetch_unit_pkg;

  localparam int IF_ID_BUS_WDTH = 70;
  localparam int ID_IF_BUS_WDTH = 34;
  localparam int TYPE_ADEF      = 0;

  typedef struct packed {
    logic [5:0]  exc_type;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic        br_taken;
    logic        br_stall;
    logic [31:0] br_target;
  } id_if_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic WIDTH x DEPTH FIFO with flush and occupancy count.
// Push into a full FIFO is accepted only when a pop frees the slot.
module fetch_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push & ~i_flush) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-outstanding fetch with instruction buffer.
// Define IFU_IBUF_BYPASS_EN to forward SRAM data to ID when ibuf is empty.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          OUTSTANDING = 2,
  parameter int          IBUF_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [31:0]               wb_flush_addr,
  input  logic [ID_IF_BUS_WDTH-1:0] id_if_bus,
  input  logic                      id_allowin,
  output logic                      if_id_valid,
  output logic [IF_ID_BUS_WDTH-1:0] if_id_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);

  localparam int PCW = $clog2(OUTSTANDING + 1);
  localparam int ICW = $clog2(IBUF_DEPTH + 1);

  id_if_t         w_br;
  if_id_t         w_ret_ent;
  if_id_t         w_adef_ent;
  if_id_t         w_ib_din;
  if_id_t         w_ib_dout;
  logic [31:0]    r_fetch_pc;
  logic [31:0]    w_pend_pc;
  logic [31:0]    w_target;
  logic [PCW-1:0] r_discard;
  logic [PCW-1:0] w_inflight;
  logic [PCW-1:0] w_disc_nxt;
  logic [ICW-1:0] w_ib_count;
  logic           r_halt;
  logic           r_run;
  logic           w_pend_full;
  logic           w_pend_empty;
  logic           w_ib_full;
  logic           w_ib_empty;
  logic           w_misalign;
  logic           w_credit;
  logic           w_accept;
  logic           w_ret;
  logic           w_ret_keep;
  logic           w_redirect;
  logic           w_adef;
  logic           w_byp;
  logic           w_ib_push;
  logic           w_ib_pop;

  assign w_br       = id_if_bus;
  assign w_misalign = (r_fetch_pc[1:0] != 2'b00);
  assign w_credit   = (int'(w_inflight) + int'(w_ib_count)) < IBUF_DEPTH;

  assign inst_sram_req   = r_run & ~r_halt & ~w_br.br_stall & ~w_misalign
                         & ~w_pend_full & w_credit;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'h2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign w_accept   = inst_sram_req & inst_sram_addr_ok;
  assign w_ret      = inst_sram_data_ok & ~w_pend_empty;
  assign w_ret_keep = w_ret & (r_discard == '0);
  assign w_redirect = flush | (w_br.br_taken & ~w_br.br_stall);
  assign w_target   = flush ? wb_flush_addr : w_br.br_target;
  assign w_adef     = r_run & ~r_halt & w_misalign & ~w_ib_full & ~w_redirect;

  // Everything still owed by the SRAM after this cycle belongs to the old path.
  assign w_disc_nxt = w_inflight + PCW'(w_accept) - PCW'(w_ret);

  assign w_ret_ent = {6'h0, w_pend_pc, inst_sram_rdata};

  always_comb begin
    w_adef_ent = '0;
    w_adef_ent.exc_type[TYPE_ADEF] = 1'b1;
    w_adef_ent.pc = r_fetch_pc;
  end

`ifdef IFU_IBUF_BYPASS_EN
  assign w_byp = w_ib_empty & w_ret_keep;
`else
  assign w_byp = 1'b0;
`endif

  assign w_ib_din    = w_adef ? w_adef_ent : w_ret_ent;
  assign w_ib_push   = (w_ret_keep & ~(w_byp & id_allowin)) | w_adef;
  assign if_id_valid = (~w_ib_empty | w_byp) & ~flush;
  assign w_ib_pop    = if_id_valid & id_allowin & ~w_byp;
  assign if_id_bus   = w_byp ? w_ret_ent : w_ib_dout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run      <= 1'b0;
      r_halt     <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_discard  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_redirect) begin
        r_halt     <= 1'b0;
        r_fetch_pc <= w_target;
        r_discard  <= w_disc_nxt;
      end else begin
        if (w_adef)   r_halt     <= 1'b1;
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_ret && r_discard != '0) r_discard <= r_discard - PCW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (OUTSTANDING)
  ) u_pend (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_din   (r_fetch_pc),
    .i_pop   (w_ret),
    .i_flush (1'b0),
    .o_dout  (w_pend_pc),
    .o_count (w_inflight),
    .o_empty (w_pend_empty),
    .o_full  (w_pend_full)
  );

  fetch_fifo #(
    .WIDTH (IF_ID_BUS_WDTH),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_ib_push),
    .i_din   (w_ib_din),
    .i_pop   (w_ib_pop),
    .i_flush (w_redirect),
    .o_dout  (w_ib_dout),
    .o_count (w_ib_count),
    .o_empty (w_ib_empty),
    .o_full  (w_ib_full)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: random SRAM/ID/redirect stimulus checked against
// an in-order fetch-stream model of what ID must receive.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int          OUTS   = 2;
  localparam int          IBD    = 4;
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic                      flush = 1'b0;
  logic [31:0]               wb_flush_addr = '0;
  logic                      br_taken = 1'b0;
  logic                      br_stall = 1'b0;
  logic [31:0]               br_target = '0;
  logic [ID_IF_BUS_WDTH-1:0] id_if_bus;
  logic                      id_allowin = 1'b1;
  logic                      if_id_valid;
  logic [IF_ID_BUS_WDTH-1:0] if_id_bus;
  logic                      inst_sram_req;
  logic                      inst_sram_wr;
  logic [1:0]                inst_sram_size;
  logic [3:0]                inst_sram_wstrb;
  logic [31:0]               inst_sram_addr;
  logic [31:0]               inst_sram_wdata;
  logic                      inst_sram_addr_ok = 1'b0;
  logic                      inst_sram_data_ok = 1'b0;
  logic [31:0]               inst_sram_rdata = '0;

  assign id_if_bus = {br_taken, br_stall, br_target};

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .OUTSTANDING (OUTS),
    .IBUF_DEPTH  (IBD),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .wb_flush_addr     (wb_flush_addr),
    .id_if_bus         (id_if_bus),
    .id_allowin        (id_allowin),
    .if_id_valid       (if_id_valid),
    .if_id_bus         (if_id_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          p_aok = 100;
  int          p_dok = 100;
  logic [31:0] sq_addr[$];
  int          sq_cyc[$];
  logic [31:0] exp_pc = RST_PC;
  bit          m_mis = 1'b0;
  bit          m_done = 1'b0;
  int          n_acc = 0;
  int          n_xfer = 0;
  int          xfer_cyc[$];
  logic        s_req;
  logic [31:0] s_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string tag, input logic [69:0] got,
                     input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [69:0] exp_bus;
    inst_sram_addr_ok = ($urandom_range(99) < p_aok);
    inst_sram_data_ok = 1'b0;
    if (sq_addr.size() != 0)
      if (cyc >= sq_cyc[0] + lat && $urandom_range(99) < p_dok)
        inst_sram_data_ok = 1'b1;
    inst_sram_rdata = inst_sram_data_ok ? memf(sq_addr[0]) : $urandom();
    #1;
    s_req  = inst_sram_req;
    s_addr = inst_sram_addr;
    if (flush) chk("flush_valid", 70'(if_id_valid), 70'(0));
    if (inst_sram_req) chk("req_align", 70'(inst_sram_addr[1:0]), 70'(0));
    if (m_mis) chk("adef_noreq", 70'(inst_sram_req), 70'(0));
    if (if_id_valid && id_allowin) begin
      if (m_done) begin
        chk("adef_stop", 70'(if_id_valid), 70'(0));
      end else begin
        if (m_mis) exp_bus = {6'(1 << TYPE_ADEF), exp_pc, 32'h0};
        else       exp_bus = {6'h0, exp_pc, memf(exp_pc)};
        chk("id_bus", if_id_bus, exp_bus);
        if (m_mis) m_done = 1'b1;
        else       exp_pc += 32'd4;
      end
      n_xfer++;
      xfer_cyc.push_back(cyc);
    end
    if (inst_sram_req && inst_sram_addr_ok) begin
      sq_addr.push_back(inst_sram_addr);
      sq_cyc.push_back(cyc);
      n_acc++;
    end
    if (inst_sram_data_ok) begin
      void'(sq_addr.pop_front());
      void'(sq_cyc.pop_front());
    end
    if (sq_addr.size() > OUTS)
      chk("inflight", 70'(sq_addr.size()), 70'(OUTS));
    if (flush || (br_taken && !br_stall)) begin
      exp_pc = flush ? wb_flush_addr : br_target;
      m_mis  = (exp_pc[1:0] != 2'b00);
      m_done = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          x0;
    bit          found;
    logic [31:0] a0;
    logic [31:0] tgt;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 70'(inst_sram_req), 70'(0));
    chk("rst_valid", 70'(if_id_valid), 70'(0));
    chk("rst_addr", 70'(inst_sram_addr), 70'(RST_PC));
    chk("const_out", 70'({inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                          inst_sram_wdata}), 70'({1'b0, 2'h2, 4'h0, 32'h0}));
    @(negedge clk);
    resetn = 1'b1;

    tick();
    chk("first_req", 70'(inst_sram_req), 70'(1));
    repeat (7) tick();
    chk("three_consec",
        70'(xfer_cyc.size() >= 3 ? xfer_cyc[2] - xfer_cyc[0] : -1), 70'(2));

    id_allowin = 1'b0;
    repeat (10) tick();
    chk("hold_req", 70'(inst_sram_req), 70'(0));
    chk("hold_buf", 70'(n_acc - n_xfer), 70'(4));
    chk("hold_sram", 70'(sq_addr.size()), 70'(0));
    x0 = n_xfer;
    id_allowin = 1'b1;
    repeat (12) tick();
    chk("hold_drain", 70'(n_xfer - x0 >= 4), 70'(1));

    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sq_addr.size() == 2) found = 1'b1;
      else tick();
    end
    chk("two_inflight", 70'(found), 70'(1));
    flush = 1'b1;
    wb_flush_addr = 32'h1c001000;
    tick();
    flush = 1'b0;
    x0 = n_xfer;
    repeat (15) tick();
    chk("flush_prog", 70'(n_xfer - x0 >= 3), 70'(1));
    lat = 1;

    flush = 1'b1;
    wb_flush_addr = RST_PC;
    tick();
    flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (inst_sram_req && inst_sram_addr == 32'h1c000010) begin
        found = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h1c000100;
        tick();
        br_taken = 1'b0;
      end else begin
        tick();
      end
    end
    chk("br_hit", 70'(found), 70'(1));
    x0 = n_xfer;
    repeat (10) tick();
    chk("br_prog", 70'(n_xfer - x0 >= 3), 70'(1));

    flush = 1'b1;
    wb_flush_addr = 32'h1c000002;
    tick();
    flush = 1'b0;
    x0 = n_xfer;
    repeat (10) tick();
    chk("adef_cnt", 70'(n_xfer - x0), 70'(1));
    chk("adef_halt_req", 70'(inst_sram_req), 70'(0));
    flush = 1'b1;
    wb_flush_addr = RST_PC;
    tick();
    flush = 1'b0;
    x0 = n_xfer;
    repeat (8) tick();
    chk("adef_resume", 70'(n_xfer - x0 >= 3), 70'(1));

    br_stall = 1'b1;
    a0 = inst_sram_addr;
    repeat (3) begin
      tick();
      chk("stall_req", 70'(s_req), 70'(0));
    end
    br_stall = 1'b0;
    tick();
    chk("stall_resume", 70'(s_req), 70'(1));
    chk("stall_pc", 70'(s_addr), 70'(a0));

    for (int blk = 0; blk < 20; blk++) begin
      lat   = $urandom_range(4, 1);
      p_aok = $urandom_range(100, 30);
      p_dok = $urandom_range(100, 30);
      for (int i = 0; i < 100; i++) begin
        int r;
        id_allowin = ($urandom_range(99) < 70);
        br_stall   = ($urandom_range(99) < 10);
        r = $urandom_range(99);
        flush    = (r < 2);
        br_taken = (r >= 2 && r < 6);
        tgt = 32'h1c000000 | ($urandom_range(1023) << 2);
        if ($urandom_range(9) == 0) tgt[1:0] = 2'b10;
        wb_flush_addr = tgt;
        br_target     = tgt;
        tick();
      end
    end

    flush = 1'b0;
    br_taken = 1'b0;
    br_stall = 1'b0;
    id_allowin = 1'b1;
    p_aok = 100;
    p_dok = 100;
    lat = 1;
    flush = 1'b1;
    wb_flush_addr = RST_PC;
    tick();
    flush = 1'b0;
    x0 = n_xfer;
    repeat (10) tick();
    chk("final_prog", 70'(n_xfer - x0 >= 5), 70'(1));

    repeat (2) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_req", 70'(inst_sram_req), 70'(0));
    chk("mid_rst_valid", 70'(if_id_valid), 70'(0));
    chk("mid_rst_addr", 70'(inst_sram_addr), 70'(RST_PC));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
